data_assembly_register: RTL and testbench

Parametrised data register that assembles a WIDTH-bit word from a stream of LANE-bit lanes delivered over a valid/ready handshake. A transfer collects a programmed number of lanes, places them in little- or big-endian lane order, sign- or zero-extends the result to WIDTH bits, and pulses Done. It sits between the memory read port and the register file / ALU operand path. It is the generalised replacement for the fixed 32-bit, 8-bit-input data register.

---
 rtl/data_assembly_register.sv | 249 ++++++++++++++++++++++++
 tb/tb_data_assembly_register.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/data_assembly_register.sv
// ---------------------------------------------------------------------------
// data_assembly_register
//
// Purpose:
//   Assembles a WIDTH-bit word from a stream of LANE-bit lanes delivered over
//   a valid/ready handshake. A transfer collects a programmed number of lanes
//   (1..LANES), places them in little- or big-endian lane order, sign- or
//   zero-extends the result to WIDTH bits and pulses Done for one cycle.
//   Sits between the memory read port and the register file / ALU operand
//   path.
//
// Optional feature:
//   DR_LEGACY_FUNSEL_EN - when defined, adds ports E and FunSel that provide
//   the single-cycle operations of the older fixed data register while the
//   block is idle.
//
// Ports:
//   Clock    in   rising-edge clock
//   Reset    in   synchronous active-low reset
//   Start    in   begin a transfer (accepted only in IDLE)
//   Count    in   lanes to collect; 0 or >LANES means LANES
//   Order    in   0 = little-endian, 1 = big-endian lane order
//   Ext      in   0 = zero-extend, 1 = sign-extend
//   Abort    in   cancel the transfer in progress (COLLECT only)
//   InValid  in   lane I is valid
//   I        in   input lane
//   E        in   legacy operation enable      (DR_LEGACY_FUNSEL_EN only)
//   FunSel   in   legacy operation select      (DR_LEGACY_FUNSEL_EN only)
//   InReady  out  a lane is accepted this cycle when InValid=1
//   DROut    out  assembled word
//   Busy     out  high in COLLECT and EXTEND
//   Done     out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module data_assembly_register #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8,
  localparam int LANES = WIDTH / LANE,
  localparam int CW    = $clog2(LANES) + 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [CW-1:0]    Count,
  input  logic             Order,
  input  logic             Ext,
  input  logic             Abort,
  input  logic             InValid,
  input  logic [LANE-1:0]  I,
`ifdef DR_LEGACY_FUNSEL_EN
  input  logic             E,
  input  logic [1:0]       FunSel,
`endif
  output logic             InReady,
  output logic [WIDTH-1:0] DROut,
  output logic             Busy,
  output logic             Done
);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LANES = CW'(LANES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_EXTEND  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic [CW-1:0]    cnt_q, cnt_d;      // lanes accepted so far (k)
  logic [CW-1:0]    n_q, n_d;          // lanes to collect (N), already normalised
  logic             order_q, order_d;
  logic             ext_q, ext_d;
  logic             done_q, done_d;

  logic [CW-1:0]    count_norm_s;
  logic [WIDTH-1:0] lane_word_s;
  logic [WIDTH-1:0] ext_word_s;

  // Write lane into slot k, leaving every other lane untouched.
  function automatic logic [WIDTH-1:0] place_lane(
    input logic [WIDTH-1:0] w,
    input logic [CW-1:0]    k,
    input logic [LANE-1:0]  lane
  );
    logic [WIDTH-1:0] res;
    res = w;
    for (int j = 0; j < LANES; j++) begin
      if (CW'(j) == k) begin
        res[j*LANE +: LANE] = lane;
      end else begin
        res[j*LANE +: LANE] = w[j*LANE +: LANE];
      end
    end
    return res;
  endfunction

  // Fill every lane at or above lane n with zeros or copies of the top bit
  // of lane n-1. With n == LANES nothing is filled and the word is unchanged.
  function automatic logic [WIDTH-1:0] extend_word(
    input logic [WIDTH-1:0] w,
    input logic [CW-1:0]    n,
    input logic             sx
  );
    logic [WIDTH-1:0] res;
    logic             fill;
    res  = w;
    fill = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (CW'(j) == (n - CNT_ONE)) begin
        fill = sx & w[j*LANE + LANE - 1];
      end else begin
        fill = fill;
      end
    end
    for (int j = 0; j < LANES; j++) begin
      if (CW'(j) >= n) begin
        res[j*LANE +: LANE] = {LANE{fill}};
      end else begin
        res[j*LANE +: LANE] = w[j*LANE +: LANE];
      end
    end
    return res;
  endfunction

  // Normalise the requested lane count: 0 or anything above LANES means LANES.
  always_comb begin
    count_norm_s = Count;
    if ((Count == CNT_ZERO) || (Count > CNT_LANES)) begin
      count_norm_s = CNT_LANES;
    end else begin
      count_norm_s = Count;
    end
  end

  // Candidate word after accepting the current lane in the latched order.
  always_comb begin
    lane_word_s = dr_q;
    if (order_q) begin
      lane_word_s = {dr_q[WIDTH-LANE-1:0], I};
    end else begin
      lane_word_s = place_lane(dr_q, cnt_q, I);
    end
  end

  // Word after the extension step of the transfer.
  always_comb begin
    ext_word_s = extend_word(dr_q, n_q, ext_q);
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    dr_d    = dr_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    order_d = order_q;
    ext_d   = ext_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          // Start wins over Abort and any legacy operation in IDLE.
          state_d = ST_COLLECT;
          dr_d    = {WIDTH{1'b0}};
          cnt_d   = CNT_ZERO;
          n_d     = count_norm_s;
          order_d = Order;
          ext_d   = Ext;
        end
`ifdef DR_LEGACY_FUNSEL_EN
        else if (E) begin
          case (FunSel)
            2'b00:   dr_d = {{(WIDTH-LANE){I[LANE-1]}}, I};
            2'b01:   dr_d = {{(WIDTH-LANE){1'b0}}, I};
            2'b10:   dr_d = {dr_q[WIDTH-LANE-1:0], I};
            2'b11:   dr_d = {I, dr_q[WIDTH-1:LANE]};
            default: dr_d = dr_q;
          endcase
        end
`endif
        else begin
          state_d = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        if (Abort) begin
          // Partial contents stay visible; the lane on the bus is dropped.
          state_d = ST_IDLE;
        end else if (InValid) begin
          dr_d  = lane_word_s;
          cnt_d = cnt_q + CNT_ONE;
          if ((cnt_q + CNT_ONE) == n_q) begin
            state_d = ST_EXTEND;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_EXTEND: begin
        dr_d    = ext_word_s;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        dr_d    = {WIDTH{1'b0}};
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      dr_q    <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
      n_q     <= CNT_LANES;
      order_q <= 1'b0;
      ext_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dr_q    <= dr_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      order_q <= order_d;
      ext_q   <= ext_d;
      done_q  <= done_d;
    end
  end

  // Outputs decoded only from registered state, no input-to-output paths.
  always_comb begin
    InReady = (state_q == ST_COLLECT);
    Busy    = (state_q == ST_COLLECT) || (state_q == ST_EXTEND);
    Done    = done_q;
    DROut   = dr_q;
  end

endmodule

// File: tb/tb_data_assembly_register.sv
module tb_data_assembly_register;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [2:0]  Count;
  logic        Order;
  logic        Ext;
  logic        Abort;
  logic        InValid;
  logic [7:0]  I;
`ifdef DR_LEGACY_FUNSEL_EN
  logic        E;
  logic [1:0]  FunSel;
`endif
  logic        InReady;
  logic [31:0] DROut;
  logic        Busy;
  logic        Done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int exp_dones = 0;
  logic [31:0] exp_q[$];

  data_assembly_register #(.WIDTH(32), .LANE(8)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .Count   (Count),
    .Order   (Order),
    .Ext     (Ext),
    .Abort   (Abort),
    .InValid (InValid),
    .I       (I),
`ifdef DR_LEGACY_FUNSEL_EN
    .E       (E),
    .FunSel  (FunSel),
`endif
    .InReady (InReady),
    .DROut   (DROut),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  // Completion monitor: every Done pops the next expected word.
  always @(negedge Clock) begin
    if (Reset === 1'b1 && Done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL done_unexpected observed=%h expected=no_done", DROut);
      end else begin
        chk("done_word", DROut, exp_q.pop_front());
      end
    end
  end

  task automatic start_xfer(input logic [2:0] cnt, input logic ord, input logic ex,
                            input logic ab, input logic [31:0] exp_word, input logic push);
    Start = 1'b1; Count = cnt; Order = ord; Ext = ex; Abort = ab;
    if (push) begin
      exp_q.push_back(exp_word);
      exp_dones++;
    end
    cyc();
    Start = 1'b0; Abort = 1'b0;
    chk("busy_after_start", {31'd0, Busy}, 32'd1);
  endtask

  task automatic send_lane(input logic [7:0] v, input int gap);
    InValid = 1'b0;
    for (int g = 0; g < gap; g++) cyc();
    chk("in_ready", {31'd0, InReady}, 32'd1);
    I = v; InValid = 1'b1;
    cyc();
    InValid = 1'b0;
  endtask

  // After the last accept: EXTEND one cycle, then Done with the final word.
  task automatic finish_xfer(input logic [31:0] exp_word);
    chk("extend_busy", {31'd0, Busy}, 32'd1);
    chk("extend_done", {31'd0, Done}, 32'd0);
    chk("extend_ready", {31'd0, InReady}, 32'd0);
    cyc();
    chk("done_pulse", {31'd0, Done}, 32'd1);
    chk("done_busy", {31'd0, Busy}, 32'd0);
    chk("done_word_tb", DROut, exp_word);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Count = 3'd0; Order = 1'b0; Ext = 1'b0;
    Abort = 1'b0; InValid = 1'b0; I = 8'h00;
`ifdef DR_LEGACY_FUNSEL_EN
    E = 1'b0; FunSel = 2'b00;
`endif
    cyc(); cyc();
    Reset = 1'b1;

    // Random partial traffic, then reset mid-transfer.
    start_xfer(3'd4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    I = 8'($urandom); InValid = 1'b1; cyc();
    I = 8'($urandom); cyc();
    Reset = 1'b0; cyc(); cyc();
    InValid = 1'b0; Reset = 1'b1;
    chk("rst_drout", DROut, 32'h0000_0000);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_ready", {31'd0, InReady}, 32'd0);

    // Four lanes, little-endian, zero-extend, back-to-back.
    start_xfer(3'd4, 1'b0, 1'b0, 1'b0, 32'h4433_2211, 1'b1);
    send_lane(8'h11, 0); send_lane(8'h22, 0); send_lane(8'h33, 0); send_lane(8'h44, 0);
    finish_xfer(32'h4433_2211);
    cyc();
    chk("done_one_cycle", {31'd0, Done}, 32'd0);

    // Two lanes, sign/zero extension in both orders.
    start_xfer(3'd2, 1'b1, 1'b1, 1'b0, 32'hFFFF_8001, 1'b1);
    send_lane(8'h80, 0); send_lane(8'h01, 0);
    finish_xfer(32'hFFFF_8001);
    start_xfer(3'd2, 1'b0, 1'b1, 1'b0, 32'hFFFF_8001, 1'b1);
    send_lane(8'h01, 0); send_lane(8'h80, 0);
    finish_xfer(32'hFFFF_8001);
    start_xfer(3'd2, 1'b0, 1'b0, 1'b0, 32'h0000_8001, 1'b1);
    send_lane(8'h01, 0); send_lane(8'h80, 0);
    finish_xfer(32'h0000_8001);

    // Three lanes with gaps and a stray Start mid-transfer.
    start_xfer(3'd3, 1'b0, 1'b1, 1'b0, 32'hFFC3_B2A1, 1'b1);
    send_lane(8'hA1, 0);
    send_lane(8'hB2, 2);
    Start = 1'b1; Count = 3'd1; Order = 1'b1; cyc(); Start = 1'b0;
    chk("stray_start_busy", {31'd0, Busy}, 32'd1);
    send_lane(8'hC3, 4);
    finish_xfer(32'hFFC3_B2A1);

    // Count=0 and Count=7 both mean four lanes.
    start_xfer(3'd0, 1'b0, 1'b1, 1'b0, 32'h8403_0201, 1'b1);
    send_lane(8'h01, 0); send_lane(8'h02, 0); send_lane(8'h03, 0); send_lane(8'h84, 0);
    finish_xfer(32'h8403_0201);
    start_xfer(3'd7, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b1);
    send_lane(8'h12, 1); send_lane(8'h34, 0); send_lane(8'h56, 0); send_lane(8'h78, 0);
    finish_xfer(32'h1234_5678);

    // Abort after two lanes; the lane presented with Abort is dropped.
    start_xfer(3'd4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    send_lane(8'hAA, 0); send_lane(8'hBB, 0);
    Abort = 1'b1; I = 8'hCC; InValid = 1'b1; cyc();
    Abort = 1'b0; InValid = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_ready", {31'd0, InReady}, 32'd0);
    chk("abort_drout", DROut, 32'h0000_BBAA);
    chk("abort_done", {31'd0, Done}, 32'd0);
    cyc();
    chk("abort_done_late", {31'd0, Done}, 32'd0);
    chk("abort_hold", DROut, 32'h0000_BBAA);

    // New single-lane transfer, then a back-to-back Start in the Done cycle
    // with Abort also raised (Start wins).
    start_xfer(3'd1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 1'b1);
    send_lane(8'hF0, 0);
    finish_xfer(32'hFFFF_FFF0);
    start_xfer(3'd2, 1'b0, 1'b0, 1'b1, 32'h0000_A55A, 1'b1);
    send_lane(8'h5A, 0); send_lane(8'hA5, 0);
    finish_xfer(32'h0000_A55A);
    cyc();

`ifdef DR_LEGACY_FUNSEL_EN
    E = 1'b1; FunSel = 2'b00; I = 8'h9C; cyc();
    chk("legacy_sext", DROut, 32'hFFFF_FF9C);
    FunSel = 2'b10; I = 8'h12; cyc();
    chk("legacy_shl", DROut, 32'hFFFF_9C12);
    FunSel = 2'b11; I = 8'h34; cyc();
    chk("legacy_shr", DROut, 32'h34FF_FF9C);
    chk("legacy_done", {31'd0, Done}, 32'd0);
    E = 1'b0; cyc();
`endif

    chk("done_count", done_cnt, exp_dones);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
